// File: rtl/serdes_lfsr_cipher_pkg.sv
// Shared types and constants for the multi-lane LFSR stream cipher.
//   state_e      : frame controller states (IDLE, RUN, DONE)
//   MODE_*       : 2-bit mode encodings (01 is folded into stream mode)
//   DEFAULT_TAPS : Galois mask for x^16+x^14+x^13+x^11+1
//   norm_mode()  : maps the unused encoding 01 onto plain stream mode
package serdes_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_STREAM  = 2'b00;
  localparam logic [1:0] MODE_CFB_ENC = 2'b10;
  localparam logic [1:0] MODE_CFB_DEC = 2'b11;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b01) ? MODE_STREAM : m;
  endfunction

endpackage

// File: rtl/serdes_lfsr_cipher_lane.sv
// One cipher lane: Galois LFSR keystream, seed load with zero-seed fix,
// CFB feedback into the LFSR MSB, registered serial bit and parallel word.
// Ports:
//   clk, rst  : clock, async active-high reset
//   load      : load seed into the LFSR (start accepted)
//   step      : advance one bit (RUN cycle)
//   mode      : latched mode (stream / CFB enc / CFB dec)
//   seed      : lane seed (key already rotated for this lane)
//   din       : input data bit
//   cnt       : bit position within the frame
//   bit_out   : registered cipher bit
//   word      : frame word, bit i = i-th cipher bit
module lfsr_lane
  import serdes_cipher_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KEY_W = 16,
  parameter int CW    = 3,
  parameter logic [KEY_W-1:0] TAPS = KEY_W'(DEFAULT_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [KEY_W-1:0] seed,
  input  logic             din,
  input  logic [CW-1:0]    cnt,
  output logic             bit_out,
  output logic [WIDTH-1:0] word
);

  logic [KEY_W-1:0] s;
  logic [KEY_W-1:0] s_next;
  logic             ks;
  logic             c;
  logic             fb;

  assign ks = s[0];
  assign c  = din ^ ks;

  // CFB: encrypt feeds back the cipher bit it produced, decrypt feeds back
  // the received cipher bit (its din), so both ends stay in lock-step.
  always_comb begin
    fb = 1'b0;
    case (mode)
      MODE_CFB_ENC: fb = c;
      MODE_CFB_DEC: fb = din;
      default:      fb = 1'b0;
    endcase
    s_next = (s >> 1) ^ (ks ? TAPS : '0) ^ {fb, {(KEY_W-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s       <= '0;
      bit_out <= 1'b0;
      word    <= '0;
    end else if (load) begin
      // An all-zero LFSR never leaves zero; substitute 1.
      s <= (seed == '0) ? KEY_W'(1) : seed;
    end else if (step) begin
      s         <= s_next;
      bit_out   <= c;
      word[cnt] <= c;
    end
  end

endmodule

// File: rtl/serdes_lfsr_cipher.sv
// Multi-lane serial LFSR cipher. Each lane XORs its din bit with its own
// keystream; lane l is seeded from key rotated left by l bits.
// Handshake: start is sampled only in IDLE or DONE; a frame then runs for
// WIDTH cycles (busy high), dout_valid marks each new dout bit one cycle
// behind busy, and done pulses for one cycle when word_out is complete.
// Ports:
//   clk, rst   : clock, async active-high reset
//   start      : frame request
//   mode       : 00 stream, 10 CFB encrypt, 11 CFB decrypt (01 = 00)
//   key        : seed, sampled with start
//   din        : one data bit per lane per RUN cycle
//   dout       : registered cipher bit per lane
//   dout_valid : dout carries a new bit
//   busy       : frame in progress
//   done       : one-cycle frame-complete pulse
//   word_out   : lane l at [l*WIDTH +: WIDTH], LSB = first bit
module serdes_lfsr_cipher
  import serdes_cipher_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int KEY_W = 16,
  parameter logic [KEY_W-1:0] TAPS = KEY_W'(DEFAULT_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [KEY_W-1:0]       key,
  input  logic [LANES-1:0]       din,
  output logic [LANES-1:0]       dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] word_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        state_q;
  state_e        state_d;
  logic          load;
  logic          step;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        // Back-to-back frames skip IDLE entirely.
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_STREAM;
      cnt        <= '0;
      dout_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_valid <= step;
      if (load) begin
        mode_q <= norm_mode(mode);
        cnt    <= '0;
      end else if (step) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int R = l % KEY_W;
    logic [2*KEY_W-1:0] key2;
    logic [KEY_W-1:0]   seed;
    logic               lane_bit;
    logic [WIDTH-1:0]   lane_word;

    // Rotate-left by R: take a KEY_W window out of the doubled key.
    assign key2 = {key, key};
    assign seed = key2[2*KEY_W-1-R -: KEY_W];

    lfsr_lane #(
      .WIDTH(WIDTH),
      .KEY_W(KEY_W),
      .CW   (CW),
      .TAPS (TAPS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .mode   (mode_q),
      .seed   (seed),
      .din    (din[l]),
      .cnt    (cnt),
      .bit_out(lane_bit),
      .word   (lane_word)
    );

    assign dout[l]                     = lane_bit;
    assign word_out[l*WIDTH +: WIDTH]  = lane_word;
  end

endmodule

// File: tb/tb_serdes_lfsr_cipher.sv
// Randomized self-checking bench for serdes_lfsr_cipher (WIDTH=8, LANES=2,
// KEY_W=16). Expected frames come from a bit-serial reference of the cipher
// rules; stimulus is driven and sampled 1 time unit after the rising edge.
module tb_serdes_lfsr_cipher;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int KEY_W = 16;
  localparam logic [15:0] REF_TAPS = 16'hB400;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [1:0]             mode;
  logic [KEY_W-1:0]       key;
  logic [LANES-1:0]       din;
  logic [LANES-1:0]       dout;
  logic                   dout_valid;
  logic                   busy;
  logic                   done;
  logic [LANES*WIDTH-1:0] word_out;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  serdes_lfsr_cipher #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .KEY_W(KEY_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .key       (key),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done),
    .word_out  (word_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: expected cipher word for one lane of one frame.
  function automatic logic [WIDTH-1:0] ref_lane(input logic [15:0] k, input int lane,
                                                input logic [1:0] m, input logic [WIDTH-1:0] d);
    int r;
    logic [15:0] s;
    logic [WIDTH-1:0] out;
    logic ks, c;
    r = lane % 16;
    s = (r == 0) ? k : ((k << r) | (k >> (16 - r)));
    if (s == 16'd0) s = 16'd1;
    out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ks = s[0];
      c = d[i] ^ ks;
      out[i] = c;
      s = (s >> 1) ^ (ks ? REF_TAPS : 16'd0);
      if (m == 2'b10) s[15] = s[15] ^ c;
      else if (m == 2'b11) s[15] = s[15] ^ d[i];
    end
    return out;
  endfunction

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Driver: issues start now (called 1 unit after an edge), feeds WIDTH bits,
  // checks every dout bit, busy/done timing and the final word. Returns in
  // the DONE cycle so a caller can chain a back-to-back frame.
  task automatic run_frame(input logic [15:0] k, input logic [1:0] m,
                           input logic [WIDTH-1:0] p0, input logic [WIDTH-1:0] p1,
                           input bit poke,
                           output logic [WIDTH-1:0] c0, output logic [WIDTH-1:0] c1);
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] e0, e1;
    exp_q.push_back(ref_lane(k, 0, m, p0));
    exp_q.push_back(ref_lane(k, 1, m, p1));
    start = 1'b1; key = k; mode = m;
    @(posedge clk); #1;
    check("busy_rise", busy, 1);
    check("done_low_start", done, 0);
    check("valid_low_start", dout_valid, 0);
    start = 1'b0;
    key = 16'($urandom);
    mode = 2'($urandom);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    for (int i = 0; i < WIDTH; i++) begin
      din = {p1[i], p0[i]};
      start = poke && (i == 2 || i == 5);
      @(posedge clk); #1;
      check("dout_bits", dout, {e1[i], e0[i]});
      check("dout_valid", dout_valid, 1);
      check("busy_run", busy, (i < WIDTH - 1) ? 1 : 0);
      check("done_time", done, (i == WIDTH - 1) ? 1 : 0);
    end
    start = 1'b0;
    c0 = word_out[0 +: WIDTH];
    c1 = word_out[WIDTH +: WIDTH];
    check("word_lane0", c0, e0);
    check("word_lane1", c1, e1);
  endtask

  initial begin
    logic [WIDTH-1:0] c0, c1, d0, d1, p0, p1;
    logic [15:0] k;
    int ds;

    rst = 1'b1; start = 1'b0; mode = 2'b00; key = '0; din = '0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word", word_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Keystream from key 1: single leading one.
    run_frame(16'h0001, 2'b00, 8'h00, 8'h00, 1'b0, c0, c1);
    check("ks_key1", c0, 8'h01);
    idle(1);
    check("done_drop", done, 0);
    check("valid_drop", dout_valid, 0);
    check("dout_hold", dout, {c1[WIDTH-1], c0[WIDTH-1]});
    // Zero key must behave exactly like key 1 on lane 0.
    run_frame(16'h0000, 2'b00, 8'h00, 8'h00, 1'b0, c0, c1);
    check("ks_key0", c0, 8'h01);
    idle(2);

    // Lane independence: lane 1 runs from seed 01FE.
    run_frame(16'h00FF, 2'b00, 8'h00, 8'h00, 1'b0, c0, c1);
    check("lane1_seed", c1, ref_lane(16'h01FE, 0, 2'b00, 8'h00));
    check("lanes_differ", (c0 != c1) ? 1 : 0, 1);
    idle(1);

    // Round trips: stream and CFB, random keys and data.
    for (int t = 0; t < 4; t++) begin
      k = 16'($urandom);
      p0 = 8'($urandom);
      p1 = 8'($urandom);
      run_frame(k, 2'b00, p0, p1, 1'b0, c0, c1);
      idle(int'($urandom_range(1, 3)));
      run_frame(k, 2'b00, c0, c1, 1'b0, d0, d1);
      check("rt_stream0", d0, p0);
      check("rt_stream1", d1, p1);
      idle(1);
      run_frame(k, (t[0] ? 2'b10 : 2'b10), p0, p1, 1'b0, c0, c1);
      idle(1);
      run_frame(k, 2'b11, c0, c1, 1'b0, d0, d1);
      check("rt_cfb0", d0, p0);
      check("rt_cfb1", d1, p1);
      idle(1);
    end

    // Mode 01 equals stream.
    k = 16'($urandom);
    run_frame(k, 2'b01, 8'hA5, 8'h3C, 1'b0, c0, c1);
    check("mode01_is_stream", c0, ref_lane(k, 0, 2'b00, 8'hA5));
    idle(1);

    // Back-to-back, second frame with start pokes during RUN.
    ds = done_seen;
    run_frame(16'hBEEF, 2'b10, 8'h5A, 8'hC3, 1'b0, c0, c1);
    run_frame(16'h1234, 2'b00, 8'hF0, 8'h0F, 1'b1, c0, c1);
    idle(3);
    check("b2b_done_count", done_seen - ds, 2);
    check("b2b_idle_busy", busy, 0);

    // Reset in the middle of a frame.
    ds = done_seen;
    start = 1'b1; key = 16'hCAFE; mode = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      din = 2'($urandom);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dout", dout, 0);
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_word", word_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(WIDTH + 2);
    check("mid_rst_no_done", done_seen - ds, 0);
    run_frame(16'hCAFE, 2'b10, 8'h81, 8'h7E, 1'b0, c0, c1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
